led_flow_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 34 +++
 rtl/led_flow_ctrl_pattern.sv | 21 ++
 rtl/led_flow_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_led_flow_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED flow sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLOW_L = 2'd0,
        FLOW_R = 2'd1,
        PING   = 2'd2,
        FILL   = 2'd3
    } mode_t;

    localparam logic [7:0] LED_OFF = 8'hFF;

    // Last position of each pattern before it wraps (or, for ping-pong, turns).
    localparam logic [3:0] POS_LAST_FLOW_L = 4'd7;
    localparam logic [3:0] POS_LAST_FLOW_R = 4'd7;
    localparam logic [3:0] POS_LAST_PING   = 4'd7;
    localparam logic [3:0] POS_LAST_FILL   = 4'd8;

    function automatic logic [3:0] pos_last(input mode_t m);
        case (m)
            FLOW_L:  return POS_LAST_FLOW_L;
            FLOW_R:  return POS_LAST_FLOW_R;
            PING:    return POS_LAST_PING;
            default: return POS_LAST_FILL;
        endcase
    endfunction

endpackage

// File: rtl/led_flow_ctrl_pattern.sv
// Combinational pattern table: (mode, pos) -> lit mask, one bit per LED.
module led_pattern
    import led_pkg::*;
#(
    parameter int LED_W = 8
) (
    input  mode_t            mode,
    input  logic [3:0]       pos,
    output logic [LED_W-1:0] mask
);

    // Each LED decides independently whether it is lit at this position.
    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_bit
            assign mask[gi] = (mode == FLOW_R) ? (pos == 4'(LED_W - 1 - gi)) :
                              (mode == FILL)   ? (4'(gi) < pos) :
                                                 (pos == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/led_flow_ctrl.sv
// LED bank sequencer: run/pause/stop control, pattern and speed selection,
// registered active-low LED drive.
module led_flow_ctrl
    import led_pkg::*;
#(
    parameter int TICK_BASE = 5_000_000,
    parameter int LED_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_run,
    input  logic             key_stop,
    input  logic             key_mode,
    input  logic             key_speed,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode_o,
    output logic [1:0]       speed_o,
    output logic             running_o
);

    localparam logic [31:0] TICK_BASE_W = 32'(TICK_BASE);

    state_t            state_reg, state_next;
    mode_t             mode_reg, mode_next;
    logic [1:0]        speed_reg, speed_next;
    logic [31:0]       cnt_reg, cnt_next;
    logic [3:0]        pos_reg, pos_next, step_pos;
    logic              dir_reg, dir_next, step_dir;
    logic [LED_W-1:0]  led_reg, led_next;
    logic              running_reg, running_next;
    logic [31:0]       period;
    logic              tick;
    logic [LED_W-1:0]  step_mask, home_mask;

    assign period     = TICK_BASE_W >> speed_reg;
    assign tick       = (state_reg == RUN) && (cnt_reg == period - 32'd1);
    assign mode_next  = key_mode  ? mode_t'(mode_reg + 2'd1) : mode_reg;
    assign speed_next = key_speed ? (speed_reg + 2'd1) : speed_reg;

    // Mask shown after a regular step, and mask shown at position 0 of the
    // (possibly just changed) mode.
    led_pattern #(.LED_W(LED_W)) u_step (
        .mode (mode_reg),
        .pos  (step_pos),
        .mask (step_mask)
    );

    led_pattern #(.LED_W(LED_W)) u_home (
        .mode (mode_next),
        .pos  (4'd0),
        .mask (home_mask)
    );

    // Position/direction the pattern advances to on the next step.
    always_comb begin
        step_pos = pos_reg;
        step_dir = dir_reg;
        if (mode_reg == PING) begin
            if (!dir_reg) begin
                if (pos_reg == POS_LAST_PING) begin
                    step_pos = pos_reg - 4'd1;
                    step_dir = 1'b1;
                end else begin
                    step_pos = pos_reg + 4'd1;
                end
            end else begin
                if (pos_reg == 4'd0) begin
                    step_pos = 4'd1;
                    step_dir = 1'b0;
                end else begin
                    step_pos = pos_reg - 4'd1;
                end
            end
        end else begin
            step_pos = (pos_reg == pos_last(mode_reg)) ? 4'd0 : pos_reg + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; stop overrides everything else.
    always_comb begin
        state_next = state_reg;
        if (key_stop) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (key_run) state_next = RUN;
                RUN:     if (key_run) state_next = PAUSE;
                PAUSE:   if (key_run) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath/output next values: counter, position, LED image.
    always_comb begin
        cnt_next     = cnt_reg;
        pos_next     = pos_reg;
        dir_next     = dir_reg;
        led_next     = led_reg;
        if (key_stop) begin
            cnt_next = 32'd0;
            pos_next = 4'd0;
            dir_next = 1'b0;
            led_next = LED_OFF;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_run || key_mode) begin
                        cnt_next = 32'd0;
                        pos_next = 4'd0;
                        dir_next = 1'b0;
                    end
                    if (key_run) led_next = ~home_mask;
                    if (key_speed) cnt_next = 32'd0;
                end
                RUN: begin
                    cnt_next = cnt_reg + 32'd1;
                    if (tick) begin
                        cnt_next = 32'd0;
                        pos_next = step_pos;
                        dir_next = step_dir;
                        led_next = ~step_mask;
                    end
                    if (key_speed) cnt_next = 32'd0;
                    // A mode change restarts the new pattern even on a step tick.
                    if (key_mode) begin
                        cnt_next = 32'd0;
                        pos_next = 4'd0;
                        dir_next = 1'b0;
                        led_next = ~home_mask;
                    end
                end
                PAUSE: begin
                    if (key_speed) cnt_next = 32'd0;
                    if (key_mode) begin
                        cnt_next = 32'd0;
                        pos_next = 4'd0;
                        dir_next = 1'b0;
                        led_next = ~home_mask;
                    end
                end
                default: begin
                    led_next = LED_OFF;
                end
            endcase
        end
        running_next = (state_next == RUN);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg    <= FLOW_L;
            speed_reg   <= 2'd0;
            cnt_reg     <= 32'd0;
            pos_reg     <= 4'd0;
            dir_reg     <= 1'b0;
            led_reg     <= LED_OFF;
            running_reg <= 1'b0;
        end else begin
            mode_reg    <= mode_next;
            speed_reg   <= speed_next;
            cnt_reg     <= cnt_next;
            pos_reg     <= pos_next;
            dir_reg     <= dir_next;
            led_reg     <= led_next;
            running_reg <= running_next;
        end
    end

    assign led       = led_reg;
    assign mode_o    = mode_reg;
    assign speed_o   = speed_reg;
    assign running_o = running_reg;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with an 8-cycle base step.
module tb_led_flow_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_run;
    logic       key_stop;
    logic       key_mode;
    logic       key_speed;
    logic [7:0] led;
    logic [1:0] mode_o;
    logic [1:0] speed_o;
    logic       running_o;

    int checks;
    int failures;

    led_flow_ctrl #(.TICK_BASE(8), .LED_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_run   (key_run),
        .key_stop  (key_stop),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .led       (led),
        .mode_o    (mode_o),
        .speed_o   (speed_o),
        .running_o (running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keys are {stop, run, mode, speed}; called at a negedge, held for n edges,
    // returns at the negedge following the last capturing edge.
    task automatic hold_keys(input logic [3:0] k, input int n);
        {key_stop, key_run, key_mode, key_speed} = k;
        repeat (n) @(negedge clk);
        {key_stop, key_run, key_mode, key_speed} = 4'b0000;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (led !== 8'hFF || mode_o !== 2'd0 || speed_o !== 2'd0 || running_o !== 1'b0) begin
            failures++;
            $display("FAIL reset led=%h mode=%0d speed=%0d run=%b exp FF/0/0/0", led, mode_o, speed_o, running_o);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 8'hFF || running_o !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold cyc%0d led=%h run=%b exp FF/0", i, led, running_o);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_flow_left();
        logic [7:0] one;
        logic [7:0] exp_led;
        logic [7:0] prev;
        one = 8'h01;
        hold_keys(4'b0100, 1);
        checks++;
        if (led !== 8'hFE || running_o !== 1'b1) begin
            failures++;
            $display("FAIL flow_start led=%h run=%b exp FE/1", led, running_o);
        end
        prev = 8'hFE;
        for (int k = 1; k <= 8; k++) begin
            exp_led = ~(one << (k % 8));
            wait_cycles(7);
            checks++;
            if (led !== prev) begin
                failures++;
                $display("FAIL flow_hold%0d led=%h exp=%h", k, led, prev);
            end
            wait_cycles(1);
            checks++;
            if (led !== exp_led) begin
                failures++;
                $display("FAIL flow_step%0d led=%h exp=%h", k, led, exp_led);
            end
            prev = exp_led;
        end
        $display("test_flow_left done");
    endtask

    task automatic test_ping_pong();
        logic [7:0] exp_tab [15];
        exp_tab = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                    8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD};
        hold_keys(4'b1000, 1);
        hold_keys(4'b0010, 1);
        hold_keys(4'b0010, 1);
        checks++;
        if (led !== 8'hFF || mode_o !== 2'd2 || running_o !== 1'b0) begin
            failures++;
            $display("FAIL ping_idle led=%h mode=%0d run=%b exp FF/2/0", led, mode_o, running_o);
        end
        hold_keys(4'b0100, 1);
        checks++;
        if (led !== 8'hFE) begin
            failures++;
            $display("FAIL ping_start led=%h exp=FE", led);
        end
        for (int k = 0; k < 15; k++) begin
            wait_cycles(8);
            checks++;
            if (led !== exp_tab[k]) begin
                failures++;
                $display("FAIL ping_step%0d led=%h exp=%h", k + 1, led, exp_tab[k]);
            end
        end
        $display("test_ping_pong done");
    endtask

    task automatic test_speed();
        hold_keys(4'b1000, 1);
        hold_keys(4'b0010, 1);
        hold_keys(4'b0010, 1);
        hold_keys(4'b0100, 1);
        checks++;
        if (led !== 8'hFE || mode_o !== 2'd0) begin
            failures++;
            $display("FAIL speed_start led=%h mode=%0d exp FE/0", led, mode_o);
        end
        hold_keys(4'b0001, 1);
        checks++;
        if (speed_o !== 2'd1) begin
            failures++;
            $display("FAIL speed_one speed=%0d exp=1", speed_o);
        end
        wait_cycles(3);
        checks++;
        if (led !== 8'hFE) begin
            failures++;
            $display("FAIL speed_hold led=%h exp=FE", led);
        end
        wait_cycles(1);
        checks++;
        if (led !== 8'hFD) begin
            failures++;
            $display("FAIL speed_step1 led=%h exp=FD", led);
        end
        wait_cycles(4);
        checks++;
        if (led !== 8'hFB) begin
            failures++;
            $display("FAIL speed_step2 led=%h exp=FB", led);
        end
        // Third press lands on a 1-cycle step tick: the step must still occur.
        hold_keys(4'b0001, 3);
        checks++;
        if (speed_o !== 2'd0 || led !== 8'hF7) begin
            failures++;
            $display("FAIL speed_wrap speed=%0d led=%h exp 0/F7", speed_o, led);
        end
        wait_cycles(7);
        checks++;
        if (led !== 8'hF7) begin
            failures++;
            $display("FAIL speed0_hold led=%h exp=F7", led);
        end
        wait_cycles(1);
        checks++;
        if (led !== 8'hEF) begin
            failures++;
            $display("FAIL speed0_step led=%h exp=EF", led);
        end
        $display("test_speed done");
    endtask

    task automatic test_pause();
        wait_cycles(2);
        hold_keys(4'b0100, 1);
        checks++;
        if (running_o !== 1'b0 || led !== 8'hEF) begin
            failures++;
            $display("FAIL pause_enter run=%b led=%h exp 0/EF", running_o, led);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (led !== 8'hEF) begin
                failures++;
                $display("FAIL pause_hold cyc%0d led=%h exp=EF", i, led);
            end
        end
        hold_keys(4'b0100, 1);
        checks++;
        if (running_o !== 1'b1 || led !== 8'hEF) begin
            failures++;
            $display("FAIL pause_resume run=%b led=%h exp 1/EF", running_o, led);
        end
        wait_cycles(4);
        checks++;
        if (led !== 8'hEF) begin
            failures++;
            $display("FAIL resume_hold led=%h exp=EF", led);
        end
        wait_cycles(1);
        checks++;
        if (led !== 8'hDF) begin
            failures++;
            $display("FAIL resume_step led=%h exp=DF", led);
        end
        $display("test_pause done");
    endtask

    task automatic test_mode_tick_stop();
        hold_keys(4'b0010, 2);
        checks++;
        if (mode_o !== 2'd2 || led !== 8'hFE) begin
            failures++;
            $display("FAIL mode_run mode=%0d led=%h exp 2/FE", mode_o, led);
        end
        wait_cycles(7);
        // This press coincides with the step tick.
        hold_keys(4'b0010, 1);
        checks++;
        if (mode_o !== 2'd3 || led !== 8'hFF || running_o !== 1'b1) begin
            failures++;
            $display("FAIL mode_on_tick mode=%0d led=%h run=%b exp 3/FF/1", mode_o, led, running_o);
        end
        wait_cycles(7);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL fill_hold led=%h exp=FF", led);
        end
        wait_cycles(1);
        checks++;
        if (led !== 8'hFE) begin
            failures++;
            $display("FAIL fill_step1 led=%h exp=FE", led);
        end
        wait_cycles(8);
        checks++;
        if (led !== 8'hFC) begin
            failures++;
            $display("FAIL fill_step2 led=%h exp=FC", led);
        end
        hold_keys(4'b1010, 1);
        checks++;
        if (led !== 8'hFF || running_o !== 1'b0 || mode_o !== 2'd0) begin
            failures++;
            $display("FAIL stop_mode led=%h run=%b mode=%0d exp FF/0/0", led, running_o, mode_o);
        end
        wait_cycles(8);
        checks++;
        if (led !== 8'hFF) begin
            failures++;
            $display("FAIL stop_hold led=%h exp=FF", led);
        end
        $display("test_mode_tick_stop done");
    endtask

    task automatic test_back_to_back_reset();
        hold_keys(4'b0110, 1);
        checks++;
        if (mode_o !== 2'd1 || led !== 8'h7F || running_o !== 1'b1) begin
            failures++;
            $display("FAIL run_mode mode=%0d led=%h run=%b exp 1/7F/1", mode_o, led, running_o);
        end
        hold_keys(4'b0001, 1);
        wait_cycles(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 8'hFF || mode_o !== 2'd0 || speed_o !== 2'd0 || running_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset led=%h mode=%0d speed=%0d run=%b exp FF/0/0/0", led, mode_o, speed_o, running_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold_keys(4'b0100, 1);
        checks++;
        if (led !== 8'hFE) begin
            failures++;
            $display("FAIL post_reset_start led=%h exp=FE", led);
        end
        wait_cycles(8);
        checks++;
        if (led !== 8'hFD) begin
            failures++;
            $display("FAIL post_reset_step led=%h exp=FD", led);
        end
        $display("test_back_to_back_reset done");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_run   = 1'b0;
        key_stop  = 1'b0;
        key_mode  = 1'b0;
        key_speed = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_flow_left();
        test_ping_pong();
        test_speed();
        test_pause();
        test_mode_tick_stop();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
